// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment message scheduler.
// State encodings double as the display mode code.
package seven_seg_pkg;

    localparam int SUM_W   = 4;
    localparam int CANDY_W = 3;
    localparam int CODE_W  = 4;

    typedef enum logic [1:0] {
        LIVE = 2'b00,
        VEND = 2'b01,
        ERR  = 2'b10
    } state_t;

    localparam logic [1:0] MODE_LIVE = 2'b00;
    localparam logic [1:0] MODE_VEND = 2'b01;
    localparam logic [1:0] MODE_ERR  = 2'b10;

    function automatic logic [1:0] mode_of(input state_t s);
        case (s)
            VEND:    return MODE_VEND;
            ERR:     return MODE_ERR;
            default: return MODE_LIVE;
        endcase
    endfunction

endpackage

// File: rtl/seven_seg_tick_prescaler.sv
// Free-running modulo-TICK_DIV counter producing a one-cycle tick enable.
// Also usable as the column-scan clock enable.
module seven_seg_tick_prescaler #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] tick_cnt;

    always_ff @(posedge clk) begin
        if (!reset)
            tick_cnt <= '0;
        else if (tick_cnt == CNT_LAST)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + CNT_W'(1);
    end

    assign tick = (tick_cnt == CNT_LAST);

endmodule

// File: rtl/seven_seg_msg_sched.sv
// Display ownership scheduler: live coin sum, held vend message, held error message.
// Optional ERR blink enabled by defining SEVEN_SEG_SCHED_BLINK_EN.
module seven_seg_msg_sched
    import seven_seg_pkg::*;
#(
    parameter int TICK_DIV    = 50000,
    parameter int HOLD_TICKS  = 1000,
    parameter int BLINK_TICKS = 250
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               coin_upd,
    input  logic [SUM_W-1:0]   sum_in,
    input  logic               vend_req,
    input  logic [CANDY_W-1:0] candy_in,
    input  logic               err_req,
    input  logic [CODE_W-1:0]  err_code,
    output logic [SUM_W-1:0]   disp_sum,
    output logic [CANDY_W-1:0] disp_candy,
    output logic [1:0]         disp_mode,
    output logic               blank,
    output logic               busy
);

    generate
        if (TICK_DIV < 2) begin : g_bad_div
            $error("TICK_DIV must be >= 2");
        end
        if (HOLD_TICKS < 1) begin : g_bad_hold
            $error("HOLD_TICKS must be >= 1");
        end
        if (BLINK_TICKS < 1) begin : g_bad_blink
            $error("BLINK_TICKS must be >= 1");
        end
    endgenerate

    localparam int HOLD_W = (HOLD_TICKS > 2) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

    logic tick;

    seven_seg_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    state_t             state, state_n;
    logic [SUM_W-1:0]   live_sum, live_sum_n;
    logic [CODE_W-1:0]  err_latch, err_latch_n;
    logic [CANDY_W-1:0] vend_latch, vend_latch_n;
    logic [CANDY_W-1:0] vend_latch_pend, vend_latch_pend_n;
    logic               vend_pend, vend_pend_n;
    logic [HOLD_W-1:0]  hold_cnt, hold_cnt_n;
    logic               restart, err_entry, expire, blank_n;

    always_comb begin
        state_n           = state;
        live_sum_n        = coin_upd ? sum_in : live_sum;
        err_latch_n       = err_latch;
        vend_latch_n      = vend_latch;
        vend_latch_pend_n = vend_latch_pend;
        vend_pend_n       = vend_pend;
        restart           = 1'b0;
        err_entry         = 1'b0;
        expire            = (state != LIVE) && tick && (hold_cnt == HOLD_LAST);

        if (err_req) begin
            // Error always wins; a coincident vend is parked, any current vend is dropped.
            state_n     = ERR;
            err_latch_n = err_code;
            restart     = 1'b1;
            err_entry   = 1'b1;
            if (vend_req) begin
                vend_pend_n       = 1'b1;
                vend_latch_pend_n = candy_in;
            end
        end else if (state == LIVE) begin
            if (vend_req) begin
                state_n      = VEND;
                vend_latch_n = candy_in;
                restart      = 1'b1;
            end
        end else if (expire) begin
            // A vend arriving on the expiry edge supersedes any older pending data.
            if (vend_req || vend_pend) begin
                state_n      = VEND;
                vend_latch_n = vend_req ? candy_in : vend_latch_pend;
                vend_pend_n  = 1'b0;
                restart      = 1'b1;
            end else begin
                state_n = LIVE;
            end
        end else if (vend_req) begin
            vend_pend_n       = 1'b1;
            vend_latch_pend_n = candy_in;
        end

        if (restart || expire)
            hold_cnt_n = '0;
        else if (tick && state != LIVE)
            hold_cnt_n = hold_cnt + HOLD_W'(1);
        else
            hold_cnt_n = hold_cnt;
    end

`ifdef SEVEN_SEG_SCHED_BLINK_EN
    localparam int BLINK_W = (BLINK_TICKS > 2) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

    logic [BLINK_W-1:0] blink_cnt, blink_cnt_n;
    logic               blink_ph, blink_ph_n;

    always_comb begin
        blink_cnt_n = blink_cnt;
        blink_ph_n  = blink_ph;
        if (state_n != ERR || err_entry) begin
            blink_cnt_n = '0;
            blink_ph_n  = 1'b0;
        end else if (tick) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt_n = '0;
                blink_ph_n  = ~blink_ph;
            end else begin
                blink_cnt_n = blink_cnt + BLINK_W'(1);
            end
        end
        blank_n = blink_ph_n;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else begin
            blink_cnt <= blink_cnt_n;
            blink_ph  <= blink_ph_n;
        end
    end
`else
    assign blank_n = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= LIVE;
            live_sum        <= '0;
            err_latch       <= '0;
            vend_latch      <= '0;
            vend_latch_pend <= '0;
            vend_pend       <= 1'b0;
            hold_cnt        <= '0;
        end else begin
            state           <= state_n;
            live_sum        <= live_sum_n;
            err_latch       <= err_latch_n;
            vend_latch      <= vend_latch_n;
            vend_latch_pend <= vend_latch_pend_n;
            vend_pend       <= vend_pend_n;
            hold_cnt        <= hold_cnt_n;
        end
    end

    // Outputs decode the next state so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            disp_sum   <= '0;
            disp_candy <= '0;
            disp_mode  <= MODE_LIVE;
            blank      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            disp_sum   <= (state_n == ERR) ? err_latch_n : live_sum_n;
            disp_candy <= (state_n == VEND) ? vend_latch_n : '0;
            disp_mode  <= mode_of(state_n);
            blank      <= blank_n;
            busy       <= (state_n != LIVE);
        end
    end

endmodule
